ram_write_buffer: RTL and testbench

//   Write-side feeder for the dual-read-port RAM: a DEPTH-entry FIFO of (address, data) write requests.

---
 rtl/ram_write_buffer_pkg.sv | 15 +
 rtl/ram_write_buffer_fifo_core.sv | 81 ++++++++
 rtl/ram_write_buffer.sv | 97 +++++++++
 tb/tb_ram_write_buffer.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ram_write_buffer_pkg.sv
// Shared constants and the write-request type for the RAM write buffer.
// The defaults must match the dual-read-port RAM this buffer feeds.
package ram_write_buffer_pkg;

    localparam int WB_DATA_WIDTH = 16;
    localparam int WB_ADDR_WIDTH = 8;
    localparam int WB_DEPTH      = 4;
    localparam int WB_PTR_WIDTH  = $clog2(WB_DEPTH);

    typedef struct packed {
        logic [WB_ADDR_WIDTH-1:0] addr;
        logic [WB_DATA_WIDTH-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/ram_write_buffer_fifo_core.sv
// Circular FIFO of write requests: storage, head/tail pointers and occupancy count.
// Exposes every slot plus an occupancy mask so the parent can run the hazard compare.
module wb_fifo_core
    import ram_write_buffer_pkg::*;
#(
    parameter type entry_t   = wb_req_t,
    parameter int  DEPTH     = WB_DEPTH,
    parameter int  PTR_WIDTH = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push,
    input  logic                 pop,
    input  entry_t               push_entry,
    output entry_t               head_entry,
    output entry_t               entries [DEPTH],
    output logic [DEPTH-1:0]     occupied,
    output logic [PTR_WIDTH:0]   count
);

    logic [PTR_WIDTH-1:0] head_q, head_d;
    logic [PTR_WIDTH-1:0] tail_q, tail_d;
    logic [PTR_WIDTH:0]   count_q, count_d;
    logic [PTR_WIDTH-1:0] offset;
    logic                 push_ok, pop_ok;
    entry_t               mem_q [DEPTH];
    entry_t               mem_d [DEPTH];

    // NOTE: always_comb uses blocking assignments with defaults first, so no latch is inferred.
    always_comb begin
        push_ok = push && (count_q != (PTR_WIDTH+1)'(DEPTH));
        pop_ok  = pop && (count_q != '0);
        mem_d   = mem_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (push_ok) begin
            mem_d[tail_q] = push_entry;
            tail_d        = tail_q + 1'b1;
        end
        if (pop_ok) begin
            head_d = head_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // NOTE: storage is not reset; validity comes from count, so stale slots are harmless.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // A slot is live when its distance from head is below the count.
    always_comb begin
        offset = '0;
        for (int i = 0; i < DEPTH; i++) begin
            offset      = PTR_WIDTH'(i) - head_q;
            occupied[i] = ({1'b0, offset} < count_q);
        end
    end

    assign head_entry = mem_q[head_q];
    assign entries    = mem_q;
    assign count      = count_q;

endmodule

// File: rtl/ram_write_buffer.sv
// Write-side feeder for the dual-read-port RAM: request FIFO, registered write stage
// and a read-after-write hazard flag covering queued and in-flight writes.
module ram_write_buffer
    import ram_write_buffer_pkg::*;
#(
    parameter int DATA_WIDTH = WB_DATA_WIDTH,
    parameter int ADDR_WIDTH = WB_ADDR_WIDTH,
    parameter int DEPTH      = WB_DEPTH,
    parameter int PTR_WIDTH  = $clog2(DEPTH)
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  iValid,
    input  logic [ADDR_WIDTH-1:0] iAddress,
    input  logic [DATA_WIDTH-1:0] iData,
    output logic                  oReady,
    input  logic                  iDrainEnable,
    output logic                  oWriteEnable,
    output logic [ADDR_WIDTH-1:0] oWriteAddress,
    output logic [DATA_WIDTH-1:0] oWriteData,
    input  logic [ADDR_WIDTH-1:0] iLookupAddress,
    output logic                  oHazard,
    output logic [PTR_WIDTH:0]    oCount,
    output logic                  oEmpty
);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } req_t;

    req_t                  push_entry, head_entry;
    req_t                  entries [DEPTH];
    logic [DEPTH-1:0]      occupied;
    logic [PTR_WIDTH:0]    fifo_count;
    logic                  do_push, do_pop;
    logic                  we_q, we_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] data_q, data_d;

    assign push_entry = '{addr: iAddress, data: iData};

    wb_fifo_core #(
        .entry_t   (req_t),
        .DEPTH     (DEPTH),
        .PTR_WIDTH (PTR_WIDTH)
    ) u_fifo (
        .clk        (Clock),
        .rst_n      (Reset),
        .push       (do_push),
        .pop        (do_pop),
        .push_entry (push_entry),
        .head_entry (head_entry),
        .entries    (entries),
        .occupied   (occupied),
        .count      (fifo_count)
    );

    // Ready depends on count alone: a full FIFO refuses even when it pops this cycle.
    always_comb begin
        oReady  = (fifo_count < (PTR_WIDTH+1)'(DEPTH));
        do_push = iValid && oReady;
        do_pop  = iDrainEnable && (fifo_count != '0);
        we_d    = do_pop;
        addr_d  = do_pop ? head_entry.addr : addr_q;
        data_d  = do_pop ? head_entry.data : data_q;
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            we_q   <= 1'b0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            we_q   <= we_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    // The output stage counts as pending until the RAM has taken it.
    always_comb begin
        oHazard = we_q && (addr_q == iLookupAddress);
        for (int i = 0; i < DEPTH; i++) begin
            if (occupied[i] && (entries[i].addr == iLookupAddress)) begin
                oHazard = 1'b1;
            end
        end
    end

    assign oWriteEnable  = we_q;
    assign oWriteAddress = addr_q;
    assign oWriteData    = data_q;
    assign oCount        = fifo_count;
    assign oEmpty        = (fifo_count == '0);

endmodule

// File: tb/tb_ram_write_buffer.sv
// Directed bench for ram_write_buffer paired with a behavioural model of the RAM write port.
module tb_ram_write_buffer;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic        iValid = 1'b0;
    logic [7:0]  iAddress = '0;
    logic [15:0] iData = '0;
    logic        oReady;
    logic        iDrainEnable = 1'b0;
    logic        oWriteEnable;
    logic [7:0]  oWriteAddress;
    logic [15:0] oWriteData;
    logic [7:0]  iLookupAddress = '0;
    logic        oHazard;
    logic [2:0]  oCount;
    logic        oEmpty;

    int checks = 0;
    int errors = 0;

    logic [15:0] ram [256];
    logic [7:0]  log_addr [$];
    logic [15:0] log_data [$];

    ram_write_buffer dut (
        .Clock          (Clock),
        .Reset          (Reset),
        .iValid         (iValid),
        .iAddress       (iAddress),
        .iData          (iData),
        .oReady         (oReady),
        .iDrainEnable   (iDrainEnable),
        .oWriteEnable   (oWriteEnable),
        .oWriteAddress  (oWriteAddress),
        .oWriteData     (oWriteData),
        .iLookupAddress (iLookupAddress),
        .oHazard        (oHazard),
        .oCount         (oCount),
        .oEmpty         (oEmpty)
    );

    always #5 Clock = ~Clock;

    // RAM write port model: captures on the edge where oWriteEnable is seen high.
    always @(posedge Clock) begin
        if (oWriteEnable) begin
            ram[oWriteAddress] <= oWriteData;
            log_addr.push_back(oWriteAddress);
            log_data.push_back(oWriteData);
        end
    end

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b0;
        #12;
        checks++; if (oWriteEnable !== 1'b0) begin errors++; $display("FAIL reset_we got %0h exp 0", oWriteEnable); end
        checks++; if (oCount !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", oCount); end
        checks++; if (oEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty got %0h exp 1", oEmpty); end
        checks++; if (oReady !== 1'b1) begin errors++; $display("FAIL reset_ready got %0h exp 1", oReady); end
        checks++; if ({oWriteAddress, oWriteData} !== 24'h0) begin errors++; $display("FAIL reset_outregs got %0h exp 0", {oWriteAddress, oWriteData}); end
        @(negedge Clock);
        Reset = 1'b1;
        step();
    endtask

    task automatic test_single_write();
        iDrainEnable = 1'b1; iLookupAddress = 8'h05;
        iValid = 1'b1; iAddress = 8'h05; iData = 16'hABCD;
        step();
        iValid = 1'b0;
        checks++; if (oWriteEnable !== 1'b0) begin errors++; $display("FAIL single_accept_we got %0h exp 0", oWriteEnable); end
        checks++; if (oHazard !== 1'b1) begin errors++; $display("FAIL single_hazard_queued got %0h exp 1", oHazard); end
        step();
        checks++; if ({oWriteEnable, oWriteAddress, oWriteData} !== {1'b1, 8'h05, 16'hABCD}) begin errors++; $display("FAIL single_write got %0h exp %0h", {oWriteEnable, oWriteAddress, oWriteData}, {1'b1, 8'h05, 16'hABCD}); end
        step();
        checks++; if (oWriteEnable !== 1'b0) begin errors++; $display("FAIL single_we_one_cycle got %0h exp 0", oWriteEnable); end
        checks++; if (ram[8'h05] !== 16'hABCD) begin errors++; $display("FAIL single_ram got %0h exp abcd", ram[8'h05]); end
    endtask

    task automatic test_full();
        int base;
        iDrainEnable = 1'b0;
        for (int i = 0; i < 4; i++) begin
            iValid = 1'b1; iAddress = 8'h20 + 8'(i); iData = 16'h1000 + 16'(i);
            step();
        end
        checks++; if (oReady !== 1'b0) begin errors++; $display("FAIL full_ready got %0h exp 0", oReady); end
        checks++; if (oCount !== 3'd4) begin errors++; $display("FAIL full_count got %0d exp 4", oCount); end
        iAddress = 8'h2F; iData = 16'hDEAD;
        step();
        iValid = 1'b0;
        checks++; if (oCount !== 3'd4) begin errors++; $display("FAIL full_reject_count got %0d exp 4", oCount); end
        base = log_addr.size();
        iDrainEnable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            checks++; if ({oWriteEnable, oWriteAddress, oWriteData} !== {1'b1, 8'h20 + 8'(i), 16'h1000 + 16'(i)}) begin errors++; $display("FAIL full_drain%0d got %0h exp %0h", i, {oWriteEnable, oWriteAddress, oWriteData}, {1'b1, 8'h20 + 8'(i), 16'h1000 + 16'(i)}); end
        end
        checks++; if (oEmpty !== 1'b1) begin errors++; $display("FAIL full_empty got %0h exp 1", oEmpty); end
        step(); step();
        checks++; if (log_addr.size() !== base + 4) begin errors++; $display("FAIL full_write_count got %0d exp %0d", log_addr.size() - base, 4); end
        checks++; if (ram[8'h2F] !== 16'h0000) begin errors++; $display("FAIL full_rejected_ram got %0h exp 0", ram[8'h2F]); end
    endtask

    task automatic test_back_to_back();
        int base;
        base = log_addr.size();
        iDrainEnable = 1'b1;
        for (int k = 0; k < 10; k++) begin
            iValid = 1'b1; iAddress = 8'h40 + 8'(k); iData = 16'h3000 + 16'(k) * 16'h11;
            step();
            checks++; if (oCount !== 3'd1) begin errors++; $display("FAIL b2b_count%0d got %0d exp 1", k, oCount); end
        end
        iValid = 1'b0;
        step(); step(); step();
        checks++; if (log_addr.size() !== base + 10) begin errors++; $display("FAIL b2b_writes got %0d exp 10", log_addr.size() - base); end
        for (int k = 0; k < 10; k++) begin
            if (base + k < log_addr.size()) begin
                checks++; if ({log_addr[base+k], log_data[base+k]} !== {8'h40 + 8'(k), 16'h3000 + 16'(k) * 16'h11}) begin errors++; $display("FAIL b2b_order%0d got %0h exp %0h", k, {log_addr[base+k], log_data[base+k]}, {8'h40 + 8'(k), 16'h3000 + 16'(k) * 16'h11}); end
            end
            checks++; if (ram[8'h40 + 8'(k)] !== 16'h3000 + 16'(k) * 16'h11) begin errors++; $display("FAIL b2b_ram%0d got %0h exp %0h", k, ram[8'h40 + 8'(k)], 16'h3000 + 16'(k) * 16'h11); end
        end
    endtask

    task automatic test_hazard();
        iDrainEnable = 1'b1; iLookupAddress = 8'h10;
        iValid = 1'b1; iAddress = 8'h10; iData = 16'h1111;
        step();
        checks++; if (oHazard !== 1'b1) begin errors++; $display("FAIL haz_first_queued got %0h exp 1", oHazard); end
        iData = 16'h2222;
        step();
        iValid = 1'b0;
        checks++; if (oHazard !== 1'b1) begin errors++; $display("FAIL haz_both_pending got %0h exp 1", oHazard); end
        iLookupAddress = 8'h11; #1;
        checks++; if (oHazard !== 1'b0) begin errors++; $display("FAIL haz_other_addr got %0h exp 0", oHazard); end
        iLookupAddress = 8'h10;
        step();
        checks++; if ({oHazard, oWriteData} !== {1'b1, 16'h2222}) begin errors++; $display("FAIL haz_second_out got %0h exp %0h", {oHazard, oWriteData}, {1'b1, 16'h2222}); end
        step();
        checks++; if (oHazard !== 1'b0) begin errors++; $display("FAIL haz_cleared got %0h exp 0", oHazard); end
        checks++; if (ram[8'h10] !== 16'h2222) begin errors++; $display("FAIL haz_last_wins got %0h exp 2222", ram[8'h10]); end
    endtask

    task automatic test_mid_reset();
        int base;
        iDrainEnable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            iValid = 1'b1; iAddress = 8'h50 + 8'(i); iData = 16'h5000 + 16'(i);
            step();
        end
        iValid = 1'b0;
        iDrainEnable = 1'b1;
        step();
        checks++; if ({oWriteEnable, oCount} !== {1'b1, 3'd2}) begin errors++; $display("FAIL rst_pre_state got %0h exp %0h", {oWriteEnable, oCount}, {1'b1, 3'd2}); end
        base = log_addr.size();
        #2 Reset = 1'b0;
        #1;
        checks++; if (oWriteEnable !== 1'b0) begin errors++; $display("FAIL rst_we got %0h exp 0", oWriteEnable); end
        checks++; if ({oCount, oEmpty} !== {3'd0, 1'b1}) begin errors++; $display("FAIL rst_count got %0h exp %0h", {oCount, oEmpty}, {3'd0, 1'b1}); end
        @(negedge Clock);
        Reset = 1'b1;
        step(); step(); step();
        checks++; if (log_addr.size() !== base) begin errors++; $display("FAIL rst_stale_writes got %0d exp 0", log_addr.size() - base); end
        for (int i = 0; i < 3; i++) begin
            checks++; if (ram[8'h50 + 8'(i)] !== 16'h0000) begin errors++; $display("FAIL rst_ram%0d got %0h exp 0", i, ram[8'h50 + 8'(i)]); end
        end
    endtask

    task automatic test_empty_no_bypass();
        iDrainEnable = 1'b1; iLookupAddress = 8'h66;
        iValid = 1'b1; iAddress = 8'h66; iData = 16'h6666;
        #1;
        checks++; if (oHazard !== 1'b0) begin errors++; $display("FAIL nb_hazard_before got %0h exp 0", oHazard); end
        step();
        iValid = 1'b0;
        checks++; if ({oWriteEnable, oHazard} !== 2'b01) begin errors++; $display("FAIL nb_accept_cycle got %0h exp 1", {oWriteEnable, oHazard}); end
        step();
        checks++; if ({oWriteEnable, oHazard, oWriteAddress} !== {2'b11, 8'h66}) begin errors++; $display("FAIL nb_write_cycle got %0h exp %0h", {oWriteEnable, oHazard, oWriteAddress}, {2'b11, 8'h66}); end
        step();
        checks++; if ({oWriteEnable, oHazard} !== 2'b00) begin errors++; $display("FAIL nb_after got %0h exp 0", {oWriteEnable, oHazard}); end
        checks++; if (ram[8'h66] !== 16'h6666) begin errors++; $display("FAIL nb_ram got %0h exp 6666", ram[8'h66]); end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) ram[a] = '0;
        test_reset();
        test_single_write();
        test_full();
        test_back_to_back();
        test_hazard();
        test_mid_reset();
        test_empty_no_bypass();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
